fpga_config_loader: RTL
=======================

Name: fpga_config_loader

Overview:
- Synthesizable configuration loader that sits directly upstream of the `fpga` fabric instance.
- Accepts the bitstream as a valid/ready stream of WORD_W-bit words and packs them into FRAME_W-bit row frames.
- For each row, drives the frame on configs_in and pulses the one-hot row select configs_en.
- After the last row it enables the fabric flip-flops (ff_en) and then raises rdy; this replaces the file-reading testbench loader.

Parameters:
- FRAME_W, 320, width of one configuration row (fabric configs_in).
- NUM_ROWS, 172, number of configuration rows (fabric configs_en width).
- WORD_W, 32, input stream word width; FRAME_W must be a multiple of WORD_W (WPF = FRAME_W/WORD_W = 10).
- SETTLE_CYCLES, 10, idle cycles before ff_en, and again between ff_en and rdy; must be ≥1.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a load; sampled in IDLE or DONE only.
- in_data, input, WORD_W, bitstream word.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, loader accepts in_data this cycle.
- configs_in, output, FRAME_W, row frame to the fabric.
- configs_en, output, NUM_ROWS, one-hot row write strobe to the fabric.
- ff_en, output, 1, fabric flip-flop enable.
- rdy, output, 1, configuration complete, fabric usable.
- busy, output, 1, high in every state except IDLE and DONE.

Behaviour:
- Reset: state=IDLE; configs_in=0, configs_en=0, ff_en=0, rdy=0, in_ready=0, busy=0; word and row counters cleared.
- Reset mid-operation aborts the load immediately, with no partial strobe. The fabric keeps whatever rows were already written.
- States: IDLE, ASSEMBLE, SETUP, STROBE, HOLD, SETTLE_FF, SETTLE_RDY, DONE.
- IDLE: start=1 → ASSEMBLE with row=0, word=0.
- ASSEMBLE:
  - in_ready=1.
  - Each beat (in_valid&in_ready) writes in_data to frame bits [word*WORD_W +: WORD_W]; the first word of a frame is the LSBs. Then word++.
  - On beat WPF-1 → SETUP and word clears.
  - in_valid low stalls indefinitely with no timeout.
- SETUP (1 cycle): configs_in <= assembled frame; configs_en=0; in_ready=0.
- STROBE (1 cycle): configs_en = 1<<row; configs_in stable.
- HOLD (1 cycle): configs_en=0; configs_in stable.
  - If row==NUM_ROWS-1 → SETTLE_FF.
  - Otherwise row++ and → ASSEMBLE.
- Timing per frame:
  - Last beat at cycle t → configs_in valid at t+1, strobe at t+2, in_ready high again at t+4.
  - Minimum 13 cycles per frame with in_valid held high; minimum total 172*13 = 2236 cycles.
- SETTLE_FF: counts SETTLE_CYCLES cycles, then ff_en<=1 and → SETTLE_RDY.
- SETTLE_RDY: counts SETTLE_CYCLES cycles, then rdy<=1 and → DONE.
- DONE:
  - ff_en=1, rdy=1, in_ready=0; configs_in retains the last frame.
  - start=1 → ff_en and rdy drop the next cycle, counters clear, → ASSEMBLE (reload).
- start in any other state is ignored.
- in_valid outside ASSEMBLE is ignored; data is not consumed.
- configs_en is never multi-hot and never nonzero outside STROBE.
- busy is combinational from state.

Decomposition:
- Package fpga_cfg_pkg holds:
  - constants FRAME_W, NUM_ROWS, WORD_W, WPF, ROW_CNT_W = clog2(NUM_ROWS) = 8, WORD_CNT_W = clog2(WPF);
  - the state encoding localparams.
- One sub-module, cfg_frame_assembler:
  - takes beat, in_data and clear;
  - produces frame (FRAME_W) and frame_full.
- The FSM, row counter, settle counter and outputs live in fpga_config_loader.

Test Plan:
- Reset check: assert rst for 3 cycles mid-ASSEMBLE (row 5, word 4) → next cycle all outputs 0, state IDLE; a subsequent start reloads from row 0.
- Single frame: 10 words 0x00000001..0x0000000A, in_valid held high.
  - configs_in = {0xA,…,0x1}, valid 1 cycle after the last beat.
  - configs_en = 172'h1 for exactly 1 cycle, 2 cycles after the last beat.
  - in_ready low for exactly 3 cycles.
- Full load: 1720 words, with frame r = all words equal r.
  - 172 strobes; strobe r has bit r set and configs_in = {10{r[31:0]}}.
  - ff_en rises 10 cycles after the final HOLD; rdy 10 cycles after ff_en.
  - Total latency 2236+20 cycles from start.
- Backpressure: random in_valid gaps (50% duty) → identical configs_in/configs_en sequence to the full-load case; no word lost or duplicated; strobes stay one-hot.
- Spurious inputs: start pulsed during ASSEMBLE/STROBE and in_valid asserted during SETUP/HOLD/SETTLE → no effect, no extra beats consumed.
- Reload: start in DONE → ff_en and rdy drop the next cycle, busy=1, second load completes with correct frames and rdy=1 again.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared constants and state encoding for the fabric configuration loader.
// Imported by the frame assembler and the loader top.
package fpga_cfg_pkg;

    localparam int FRAME_W       = 320;
    localparam int NUM_ROWS      = 172;
    localparam int WORD_W        = 32;
    localparam int WPF           = FRAME_W / WORD_W;
    localparam int ROW_CNT_W     = $clog2(NUM_ROWS);
    localparam int WORD_CNT_W    = $clog2(WPF);
    localparam int SETTLE_CYCLES = 10;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSEMBLE   = 3'd1,
        ST_SETUP      = 3'd2,
        ST_STROBE     = 3'd3,
        ST_HOLD       = 3'd4,
        ST_SETTLE_FF  = 3'd5,
        ST_SETTLE_RDY = 3'd6,
        ST_DONE       = 3'd7
    } cfg_state_t;

endpackage

// File: rtl/fpga_config_loader_assembler.sv
// Packs WORD_W-bit stream beats into one FRAME_W-bit row frame, LSB word first.
// frame_full flags the beat that completes the frame.
module cfg_frame_assembler
    import fpga_cfg_pkg::*;
(
    input  logic               clock,
    input  logic               rst,
    input  logic               beat,
    input  logic               clear,
    input  logic [WORD_W-1:0]  in_data,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_full
);

    logic [WORD_CNT_W-1:0] word;

    assign frame_full = beat && (word == WORD_CNT_W'(WPF - 1));

    always_ff @(posedge clock) begin
        if (rst) begin
            word  <= '0;
            frame <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (beat) begin
            frame[int'(word) * WORD_W +: WORD_W] <= in_data;
            word <= frame_full ? '0 : word + WORD_CNT_W'(1);
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Streams a bitstream into the fabric row by row, then enables the fabric
// flip-flops and reports ready after two settle intervals.
module fpga_config_loader
    import fpga_cfg_pkg::*;
(
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [FRAME_W-1:0]  configs_in,
    output logic [NUM_ROWS-1:0] configs_en,
    output logic                ff_en,
    output logic                rdy,
    output logic                busy
);

    cfg_state_t           state, state_d;
    logic [ROW_CNT_W-1:0] row, row_d;
    logic [SETTLE_W-1:0]  settle, settle_d;
    logic                 ff_en_d, rdy_d;
    logic                 beat, clear, frame_full;
    logic                 last_row, settle_done;

    assign in_ready    = (state == ST_ASSEMBLE);
    assign beat        = in_valid && in_ready;
    assign last_row    = (row == ROW_CNT_W'(NUM_ROWS - 1));
    assign settle_done = (settle == SETTLE_W'(SETTLE_CYCLES - 1));

    // The assembled frame drives the fabric directly; it only changes
    // while no row strobe can be active.
    cfg_frame_assembler u_asm (
        .clock      (clock),
        .rst        (rst),
        .beat       (beat),
        .clear      (clear),
        .in_data    (in_data),
        .frame      (configs_in),
        .frame_full (frame_full)
    );

    always_comb begin
        state_d    = state;
        row_d      = row;
        settle_d   = settle;
        ff_en_d    = ff_en;
        rdy_d      = rdy;
        clear      = 1'b0;
        configs_en = '0;
        busy       = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_ASSEMBLE;
                    row_d   = '0;
                    clear   = 1'b1;
                end
            end
            ST_ASSEMBLE: begin
                if (frame_full) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                configs_en = {{(NUM_ROWS - 1){1'b0}}, 1'b1} << row;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (last_row) begin
                    state_d  = ST_SETTLE_FF;
                    settle_d = '0;
                end else begin
                    row_d   = row + ROW_CNT_W'(1);
                    state_d = ST_ASSEMBLE;
                end
            end
            ST_SETTLE_FF: begin
                if (settle_done) begin
                    ff_en_d  = 1'b1;
                    settle_d = '0;
                    state_d  = ST_SETTLE_RDY;
                end else begin
                    settle_d = settle + SETTLE_W'(1);
                end
            end
            ST_SETTLE_RDY: begin
                if (settle_done) begin
                    rdy_d    = 1'b1;
                    settle_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    settle_d = settle + SETTLE_W'(1);
                end
            end
            ST_DONE: begin
                busy = 1'b0;
                if (start) begin
                    ff_en_d  = 1'b0;
                    rdy_d    = 1'b0;
                    row_d    = '0;
                    settle_d = '0;
                    clear    = 1'b1;
                    state_d  = ST_ASSEMBLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= ST_IDLE;
            row    <= '0;
            settle <= '0;
            ff_en  <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            state  <= state_d;
            row    <= row_d;
            settle <= settle_d;
            ff_en  <= ff_en_d;
            rdy    <= rdy_d;
        end
    end

endmodule
